// File: rtl/spu_compositor.sv
// Sprite compositor: double-buffered attribute file for SPRITE_NUM rectangles
// plus background, streamed as one colour word per pixel in raster order.
module spu_compositor #(
  parameter int SPRITE_NUM = 6,
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int COORD_W    = 8,
  parameter int COLOR_W    = 9,
  parameter int ADDR_W     = 16,
  localparam int IDX_W     = $clog2(SPRITE_NUM + 1),
  localparam int DATA_W    = (COORD_W > COLOR_W) ? COORD_W : COLOR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reg_we,
  input  logic [IDX_W+2:0]   reg_addr,
  input  logic [DATA_W-1:0]  reg_wdata,
  input  logic               frame_start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLOR_W-1:0] data,
  output logic [ADDR_W-1:0]  address,
  output logic               busy,
  output logic               frame_done,
  output logic               collision
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RENDER = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [COORD_W-1:0] sh_x_r [SPRITE_NUM];
  logic [COORD_W-1:0] sh_y_r [SPRITE_NUM];
  logic [COORD_W-1:0] sh_w_r [SPRITE_NUM];
  logic [COORD_W-1:0] sh_h_r [SPRITE_NUM];
  logic [COLOR_W-1:0] sh_col_r [SPRITE_NUM];
  logic [SPRITE_NUM-1:0] sh_en_r;
  logic [COLOR_W-1:0] sh_bg_r;

  logic [COORD_W-1:0] ac_x_r [SPRITE_NUM];
  logic [COORD_W-1:0] ac_y_r [SPRITE_NUM];
  logic [COORD_W-1:0] ac_w_r [SPRITE_NUM];
  logic [COORD_W-1:0] ac_h_r [SPRITE_NUM];
  logic [COLOR_W-1:0] ac_col_r [SPRITE_NUM];
  logic [SPRITE_NUM-1:0] ac_en_r;
  logic [COLOR_W-1:0] ac_bg_r;

  logic [COORD_W-1:0] x_r, y_r;
  logic [ADDR_W-1:0]  addr_r;
  logic               collision_r;

  logic [IDX_W-1:0]   wr_idx_s;
  logic [2:0]         wr_field_s;
  logic               glob_we_s, commit_s, accept_s, last_px_s;
  logic [COORD_W:0]   px_s, py_s;
  logic [SPRITE_NUM-1:0] hit_s;
  logic               any_s, multi_s;
  logic [COLOR_W-1:0] pix_s;

  assign wr_idx_s   = reg_addr[IDX_W+2:3];
  assign wr_field_s = reg_addr[2:0];
  assign glob_we_s  = reg_we && (wr_idx_s == IDX_W'(SPRITE_NUM));
  assign commit_s   = (state_r == ST_IDLE) && frame_start;
  assign accept_s   = (state_r == ST_RENDER) && out_ready;
  assign last_px_s  = (x_r == COORD_W'(H_RES - 1)) && (y_r == COORD_W'(V_RES - 1));

  // Shadow attribute file: every register write lands here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x_r   <= '{default: '0};
      sh_y_r   <= '{default: '0};
      sh_w_r   <= '{default: '0};
      sh_h_r   <= '{default: '0};
      sh_col_r <= '{default: '0};
      sh_en_r  <= '0;
      sh_bg_r  <= '0;
    end else if (reg_we) begin
      for (int i = 0; i < SPRITE_NUM; i++) begin
        if (wr_idx_s == IDX_W'(i)) begin
          case (wr_field_s)
            3'd0:    sh_x_r[i]   <= reg_wdata[COORD_W-1:0];
            3'd1:    sh_y_r[i]   <= reg_wdata[COORD_W-1:0];
            3'd2:    sh_w_r[i]   <= reg_wdata[COORD_W-1:0];
            3'd3:    sh_h_r[i]   <= reg_wdata[COORD_W-1:0];
            3'd4:    sh_col_r[i] <= reg_wdata[COLOR_W-1:0];
            3'd5:    sh_en_r[i]  <= reg_wdata[0];
            default: ;
          endcase
        end
      end
      if (glob_we_s && (wr_field_s == 3'd0)) begin
        sh_bg_r <= reg_wdata[COLOR_W-1:0];
      end
    end
  end

  // Active set snapshot; a same-cycle write is seen only by the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_x_r   <= '{default: '0};
      ac_y_r   <= '{default: '0};
      ac_w_r   <= '{default: '0};
      ac_h_r   <= '{default: '0};
      ac_col_r <= '{default: '0};
      ac_en_r  <= '0;
      ac_bg_r  <= '0;
    end else if (commit_s) begin
      ac_x_r   <= sh_x_r;
      ac_y_r   <= sh_y_r;
      ac_w_r   <= sh_w_r;
      ac_h_r   <= sh_h_r;
      ac_col_r <= sh_col_r;
      ac_en_r  <= sh_en_r;
      ac_bg_r  <= sh_bg_r;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = frame_start ? ST_RENDER : ST_IDLE;
      ST_RENDER: state_nxt_s = (accept_s && last_px_s) ? ST_DONE : ST_RENDER;
      ST_DONE:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Raster counters; the address wraps to 0 after the last pixel so it never exceeds H_RES*V_RES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r    <= '0;
      y_r    <= '0;
      addr_r <= '0;
    end else if (commit_s) begin
      x_r    <= '0;
      y_r    <= '0;
      addr_r <= '0;
    end else if (accept_s) begin
      if (x_r == COORD_W'(H_RES - 1)) begin
        x_r <= '0;
        y_r <= (y_r == COORD_W'(V_RES - 1)) ? '0 : y_r + COORD_W'(1);
      end else begin
        x_r <= x_r + COORD_W'(1);
      end
      addr_r <= last_px_s ? '0 : addr_r + ADDR_W'(1);
    end
  end

  assign px_s = {1'b0, x_r};
  assign py_s = {1'b0, y_r};

  // Per-sprite hit test; the extra top bit keeps x+w from wrapping.
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < SPRITE_NUM; i++) begin
      hit_s[i] = ac_en_r[i]
               && (px_s >= {1'b0, ac_x_r[i]}) && (px_s < ({1'b0, ac_x_r[i]} + {1'b0, ac_w_r[i]}))
               && (py_s >= {1'b0, ac_y_r[i]}) && (py_s < ({1'b0, ac_y_r[i]} + {1'b0, ac_h_r[i]}));
    end
  end

  // Priority resolve (lowest index last so it wins) and multi-hit detect.
  always_comb begin
    pix_s   = ac_bg_r;
    any_s   = 1'b0;
    multi_s = 1'b0;
    for (int i = SPRITE_NUM - 1; i >= 0; i--) begin
      multi_s = multi_s | (any_s & hit_s[i]);
      any_s   = any_s | hit_s[i];
      pix_s   = hit_s[i] ? ac_col_r[i] : pix_s;
    end
  end

  // Sticky collision flag: a set outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_r <= 1'b0;
    end else if (accept_s && multi_s) begin
      collision_r <= 1'b1;
    end else if (glob_we_s && (wr_field_s == 3'd1)) begin
      collision_r <= 1'b0;
    end
  end

  assign out_valid  = (state_r == ST_RENDER);
  assign busy       = (state_r == ST_RENDER);
  assign frame_done = (state_r == ST_DONE);
  assign data       = pix_s;
  assign address    = addr_r;
  assign collision  = collision_r;

endmodule

// File: tb/tb_spu_compositor.sv
// Bench for spu_compositor: reference model feeds a pixel scoreboard, plus a
// table of hand-derived pixel colours and directed corner-case sequences.
module tb_spu_compositor;
  localparam int SN   = 6;
  localparam int HR   = 160;
  localparam int VR   = 120;
  localparam int NPIX = HR * VR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reg_we = 1'b0;
  logic [5:0] reg_addr = 6'd0;
  logic [8:0] reg_wdata = 9'd0;
  logic frame_start = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid, busy, frame_done, collision;
  logic [8:0] data;
  logic [15:0] address;

  always #5 clk = ~clk;

  spu_compositor dut (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .frame_start(frame_start), .out_valid(out_valid),
    .out_ready(out_ready), .data(data), .address(address), .busy(busy),
    .frame_done(frame_done), .collision(collision)
  );

  typedef struct { int addr; logic [8:0] data; bit multi; } px_t;
  typedef struct { int addr; logic [8:0] exp; } vec_t;

  px_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int cap [NPIX];
  bit exp_coll = 1'b0;

  int m_x_s [SN], m_y_s [SN], m_w_s [SN], m_h_s [SN], m_c_s [SN], m_e_s [SN];
  int m_x_a [SN], m_y_a [SN], m_w_a [SN], m_h_a [SN], m_c_a [SN], m_e_a [SN];
  int m_bg_s = 0;
  int m_bg_a = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < SN; i++) begin
      m_x_s[i] = 0; m_y_s[i] = 0; m_w_s[i] = 0; m_h_s[i] = 0; m_c_s[i] = 0; m_e_s[i] = 0;
    end
    m_x_a = m_x_s; m_y_a = m_y_s; m_w_a = m_w_s; m_h_a = m_h_s; m_c_a = m_c_s; m_e_a = m_e_s;
    m_bg_s = 0; m_bg_a = 0; exp_coll = 1'b0;
  endfunction

  function automatic void mwrite(input int idx, input int fld, input int val);
    if (idx < SN) begin
      case (fld)
        0: m_x_s[idx] = val & 255;
        1: m_y_s[idx] = val & 255;
        2: m_w_s[idx] = val & 255;
        3: m_h_s[idx] = val & 255;
        4: m_c_s[idx] = val & 511;
        5: m_e_s[idx] = val & 1;
        default: ;
      endcase
    end else if (idx == SN && fld == 0) begin
      m_bg_s = val & 511;
    end else if (idx == SN && fld == 1) begin
      exp_coll = 1'b0;
    end
  endfunction

  function automatic void commit_and_push();
    m_x_a = m_x_s; m_y_a = m_y_s; m_w_a = m_w_s; m_h_a = m_h_s; m_c_a = m_c_s; m_e_a = m_e_s;
    m_bg_a = m_bg_s;
    sb.delete();
    for (int y = 0; y < VR; y++) begin
      for (int x = 0; x < HR; x++) begin
        px_t p;
        int nh = 0;
        p.addr = y * HR + x;
        p.data = 9'(m_bg_a);
        for (int i = 0; i < SN; i++) begin
          if (m_e_a[i] != 0 && x >= m_x_a[i] && x < m_x_a[i] + m_w_a[i]
              && y >= m_y_a[i] && y < m_y_a[i] + m_h_a[i]) begin
            if (nh == 0) p.data = 9'(m_c_a[i]);
            nh++;
          end
        end
        p.multi = (nh >= 2);
        sb.push_back(p);
      end
    end
  endfunction

  task automatic wr(input int idx, input int fld, input int val);
    @(negedge clk);
    reg_we = 1'b1; reg_addr = {3'(idx), 3'(fld)}; reg_wdata = 9'(val);
    mwrite(idx, fld, val);
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic start_frame(input bit wr_too, input int idx, input int fld, input int val);
    @(negedge clk);
    frame_start = 1'b1;
    commit_and_push();
    if (wr_too) begin
      reg_we = 1'b1; reg_addr = {3'(idx), 3'(fld)}; reg_wdata = 9'(val);
      mwrite(idx, fld, val);
    end
    @(negedge clk);
    frame_start = 1'b0; reg_we = 1'b0;
  endtask

  task automatic run_frame(input int ready_pct, input int mid_at, input int ign_at, input int abort_at);
    int acc = 0;
    int cyc = 0;
    bit stalled = 1'b0, fin = 1'b0, mid_done = 1'b0, ign_done = 1'b0;
    logic [8:0] hd = 9'd0;
    logic [15:0] ha = 16'd0;
    px_t e;
    while (cyc < 4 * NPIX) begin
      reg_we = 1'b0; frame_start = 1'b0;
      check("frame_done", frame_done, fin);
      check("busy", busy, !fin);
      check("out_valid", out_valid, !fin);
      if (fin) break;
      if (acc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_data", data, 0);
        check("abort_addr", address, 0);
        check("abort_busy", busy, 0);
        check("abort_coll", collision, 0);
        model_reset();
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("abort_no_done", frame_done, 0);
          check("abort_idle", out_valid, 0);
        end
        return;
      end
      if (!mid_done && acc >= mid_at) begin
        mid_done = 1'b1;
        reg_we = 1'b1; reg_addr = {3'd0, 3'd0}; reg_wdata = 9'd20;
        mwrite(0, 0, 20);
      end
      if (!ign_done && acc >= ign_at) begin
        ign_done = 1'b1;
        frame_start = 1'b1;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      check("collision", collision, exp_coll);
      if (out_valid) begin
        if (stalled) begin
          check("hold_data", data, hd);
          check("hold_addr", address, ha);
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check("pix_addr", address, e.addr);
            check("pix_data", data, e.data);
            cap[e.addr] = int'(data);
            if (e.multi) exp_coll = 1'b1;
            acc++;
            if (acc == NPIX) fin = 1'b1;
          end
        end
        stalled = !out_ready; hd = data; ha = address;
      end
      cyc++;
      @(negedge clk);
    end
    if (!fin) check("frame_timeout", acc, NPIX);
  endtask

  initial begin
    vec_t tbl[$];
    tbl = '{'{810, 9'h007}, '{813, 9'h007}, '{814, 9'h0F0}, '{809, 9'h0F0},
            '{970, 9'h007}, '{972, 9'h007}, '{974, 9'h038}, '{1133, 9'h007},
            '{1134, 9'h038}, '{1290, 9'h0F0}, '{1292, 9'h038}, '{1450, 9'h0F0},
            '{1452, 9'h038}, '{1612, 9'h0F0}, '{158, 9'h1C0}, '{159, 9'h1C0},
            '{318, 9'h1C0}, '{478, 9'h0F0}, '{157, 9'h0F0}, '{0, 9'h0F0},
            '{7, 9'h0F0}, '{160, 9'h0F0}, '{4830, 9'h0F0}};
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", data, 0);
    check("rst_addr", address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_coll", collision, 0);
    rst_n = 1'b1;

    // Frame A: background only.
    wr(SN, 0, 'h1FF);
    start_frame(1'b0, 0, 0, 0);
    run_frame(100, NPIX + 1, NPIX + 1, -1);
    check("coll_A", collision, 0);

    // Frame B: overlapping, clipped and degenerate sprites under random backpressure.
    wr(SN, 0, 'h0F0);
    wr(0, 0, 10);  wr(0, 1, 5); wr(0, 2, 4);  wr(0, 3, 3); wr(0, 4, 'h007); wr(0, 5, 1);
    wr(1, 0, 12);  wr(1, 1, 6); wr(1, 2, 4);  wr(1, 3, 4); wr(1, 4, 'h038); wr(1, 5, 1);
    wr(2, 0, 158); wr(2, 1, 0); wr(2, 2, 10); wr(2, 3, 2); wr(2, 4, 'h1C0); wr(2, 5, 1);
    wr(3, 0, 0);   wr(3, 1, 0); wr(3, 2, 0);  wr(3, 3, 5); wr(3, 4, 'h111); wr(3, 5, 1);
    wr(4, 0, 30);  wr(4, 1, 30); wr(4, 2, 5); wr(4, 3, 0); wr(4, 4, 'h155); wr(4, 5, 1);
    wr(7, 0, 99);
    wr(0, 6, 99);
    start_frame(1'b0, 0, 0, 0);
    run_frame(75, 3000, 6000, -1);
    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("tbl_addr_%0d", tbl[i].addr), cap[tbl[i].addr], tbl[i].exp);
    end
    check("coll_B_set", collision, 1);
    wr(SN, 1, 0);
    check("coll_clear", collision, 0);

    // Frame C: moved sprite 0 appears; same-cycle bg write is not committed; reset at pixel 5000.
    start_frame(1'b1, SN, 0, 'h0AA);
    run_frame(100, NPIX + 1, NPIX + 1, 5000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
